// File: rtl/amber_wb_fetch_responder_if.sv
// 128-bit Wishbone bus between the amber core (master) and the fetch responder (slave).
interface amber_wb_fetch_responder_if;
  logic [31:0]  core_adr;
  logic [15:0]  core_sel;
  logic         core_we;
  logic [127:0] core_wdat;
  logic         core_cyc;
  logic         core_stb;
  logic [127:0] core_rdat;
  logic         core_ack;
  logic         core_err;

  modport master (
    output core_adr, core_sel, core_we, core_wdat, core_cyc, core_stb,
    input  core_rdat, core_ack, core_err
  );

  modport slave (
    input  core_adr, core_sel, core_we, core_wdat, core_cyc, core_stb,
    output core_rdat, core_ack, core_err
  );
endinterface

// File: rtl/amber_wb_fetch_responder.sv
// Wishbone slave feeding queued 32-bit instructions to the amber core's 128-bit fetch bus.
// Define AMBER_FETCH_RESPONDER_ERR_EN to answer empty-queue reads with core_err instead of FILLER.
module amber_wb_fetch_responder #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] FILLER      = 32'hF0801003
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inst_valid,
  input  logic [31:0]              inst_data,
  output logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   q_level,
  amber_wb_fetch_responder_if.slave bus,
  output logic                     wr_valid,
  output logic [31:0]              wr_adr,
  output logic [31:0]              wr_dat,
  output logic [15:0]              fetch_count
);

`ifdef AMBER_FETCH_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int unsigned PW        = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_LVL  = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   LVL_ONE   = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [3:0]    WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [31:0]   lat_adr;
  logic          lat_we;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic          req;
  logic          go_resp;
  logic [31:0]   cur_adr;
  logic          cur_we;
  logic [1:0]    lane;
  logic          q_empty;
  logic          q_full;
  logic          push;
  logic          pop;
  logic          rd_err;
  logic [31:0]   head;
  logic [127:0]  rdat_next;

  assign req        = bus.core_cyc & bus.core_stb;
  assign q_empty    = (count == '0);
  assign q_full     = (count == FULL_LVL);
  assign inst_ready = ~q_full;
  assign q_level    = count;

  // The response is decided on the edge that enters RESP; in IDLE (zero wait states)
  // the request fields have not been latched yet, so they come straight off the bus.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    go_resp = 1'b0;
    cur_adr = lat_adr;
    cur_we  = lat_we;
    unique case (state)
      S_IDLE: begin
        cur_adr = bus.core_adr;
        cur_we  = bus.core_we;
        go_resp = req && (WAIT_STATES == 0);
      end
      S_WAIT:  go_resp = req && (wait_cnt == WAIT_LAST);
      default: go_resp = 1'b0;
    endcase
  end

  assign lane   = cur_adr[3:2];
  assign rd_err = ERR_EN && go_resp && !cur_we && q_empty;
  assign pop    = go_resp && !cur_we && !q_empty;
  // Full is judged before any same-cycle pop, so a pop never frees room for a push.
  assign push   = inst_valid && !q_full;
  assign head   = q_empty ? FILLER : mem[rd_ptr];

  always_comb begin
    rdat_next = {4{FILLER}};
    rdat_next[{lane, 5'b00000} +: 32] = head;
  end

  // NOTE: the storage array has no reset; entries are only ever read behind count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= inst_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      lat_adr       <= '0;
      lat_we        <= 1'b0;
      bus.core_ack  <= 1'b0;
      bus.core_err  <= 1'b0;
      bus.core_rdat <= '0;
      wr_valid      <= 1'b0;
      wr_adr        <= '0;
      wr_dat        <= '0;
      fetch_count   <= '0;
    end else begin
      bus.core_ack <= 1'b0;
      bus.core_err <= 1'b0;
      wr_valid     <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (req) begin
            lat_adr  <= bus.core_adr;
            lat_we   <= bus.core_we;
            wait_cnt <= '0;
            state    <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req)                       state    <= S_IDLE;
          else if (wait_cnt == WAIT_LAST) state    <= S_RESP;
          else                            wait_cnt <= wait_cnt + 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // ack/err and their data are registered so they are valid for the whole RESP cycle.
      if (go_resp) begin
        if (rd_err) begin
          bus.core_err <= 1'b1;
        end else begin
          bus.core_ack <= 1'b1;
          if (cur_we) begin
            wr_valid <= 1'b1;
            wr_adr   <= cur_adr;
            wr_dat   <= bus.core_wdat[{lane, 5'b00000} +: 32];
          end else begin
            bus.core_rdat <= rdat_next;
            if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_amber_wb_fetch_responder.sv
// Randomized self-checking bench for amber_wb_fetch_responder against a queue-based reference model.
module tb_amber_wb_fetch_responder;
  localparam int unsigned DEPTH  = 8;
  localparam logic [31:0] FILLER = 32'hF0801003;

`ifdef AMBER_FETCH_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance, zero wait states
  logic        inst_valid = 1'b0;
  logic [31:0] inst_data  = '0;
  logic        inst_ready;
  logic [3:0]  q_level;
  logic        wr_valid;
  logic [31:0] wr_adr, wr_dat;
  logic [15:0] fetch_count;
  amber_wb_fetch_responder_if bus0 ();

  // Second instance, two wait states
  logic        inst_valid_w = 1'b0;
  logic [31:0] inst_data_w  = '0;
  logic        inst_ready_w;
  logic [3:0]  q_level_w;
  logic        wr_valid_w;
  logic [31:0] wr_adr_w, wr_dat_w;
  logic [15:0] fetch_count_w;
  amber_wb_fetch_responder_if bus_w ();

  amber_wb_fetch_responder #(.DEPTH(DEPTH), .WAIT_STATES(0), .FILLER(FILLER)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_ready(inst_ready), .q_level(q_level), .bus(bus0.slave), .wr_valid(wr_valid),
    .wr_adr(wr_adr), .wr_dat(wr_dat), .fetch_count(fetch_count));

  amber_wb_fetch_responder #(.DEPTH(DEPTH), .WAIT_STATES(2), .FILLER(FILLER)) dut_ws (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid_w), .inst_data(inst_data_w),
    .inst_ready(inst_ready_w), .q_level(q_level_w), .bus(bus_w.slave), .wr_valid(wr_valid_w),
    .wr_adr(wr_adr_w), .wr_dat(wr_dat_w), .fetch_count(fetch_count_w));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain queue of pending instructions plus the visible counters
  logic [31:0]  mq[$];
  int unsigned  m_fc = 0;
  logic [127:0] m_rdat = '0;
  logic [31:0]  m_wadr = '0;
  logic [31:0]  m_wdat = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] lane_word(input logic [31:0] adr, input logic [31:0] w);
    logic [127:0] r;
    r = {4{FILLER}};
    r[adr[3:2]*32 +: 32] = w;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus0.core_cyc = 1'b0;
    bus0.core_stb = 1'b0;
    bus0.core_we  = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    check("inst_ready", inst_ready, mq.size() < DEPTH);
    inst_valid = 1'b1;
    inst_data  = d;
    tick();
    inst_valid = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(d);
    check("push_level", q_level, mq.size());
  endtask

  task automatic do_read(input logic [31:0] adr, input bit push_too, input logic [31:0] pdat);
    bit          empty, exp_err, accept;
    logic [31:0] head;
    int          waited;
    empty   = (mq.size() == 0);
    head    = empty ? FILLER : mq[0];
    exp_err = ERR_EN && empty;
    accept  = push_too && (mq.size() < DEPTH);
    bus0.core_adr = adr;
    bus0.core_we  = 1'b0;
    bus0.core_sel = 16'hFFFF;
    bus0.core_cyc = 1'b1;
    bus0.core_stb = 1'b1;
    if (push_too) begin
      inst_valid = 1'b1;
      inst_data  = pdat;
    end
    waited = 0;
    do begin
      tick();
      inst_valid = 1'b0;
      waited++;
    end while (!(bus0.core_ack || bus0.core_err) && waited < 8);
    if (!empty) void'(mq.pop_front());
    if (accept) mq.push_back(pdat);
    if (!exp_err) begin
      m_rdat = lane_word(adr, head);
      if (m_fc < 16'hFFFF) m_fc++;
    end
    check("rd_ack", bus0.core_ack, !exp_err);
    check("rd_err", bus0.core_err, exp_err);
    check("rd_rdat", bus0.core_rdat, m_rdat);
    check("rd_level", q_level, mq.size());
    check("rd_fcount", fetch_count, m_fc);
    bus_idle();
    tick();
    check("rd_single", {bus0.core_ack, bus0.core_err}, 2'b00);
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [127:0] wdat, input logic [15:0] sel);
    int waited;
    bus0.core_adr  = adr;
    bus0.core_we   = 1'b1;
    bus0.core_sel  = sel;
    bus0.core_wdat = wdat;
    bus0.core_cyc  = 1'b1;
    bus0.core_stb  = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(bus0.core_ack || bus0.core_err) && waited < 8);
    m_wadr = adr;
    m_wdat = wdat[adr[3:2]*32 +: 32];
    check("wr_ack", {bus0.core_ack, bus0.core_err}, 2'b10);
    check("wr_valid", wr_valid, 1'b1);
    check("wr_adr", wr_adr, m_wadr);
    check("wr_dat", wr_dat, m_wdat);
    check("wr_level", q_level, mq.size());
    check("wr_fcount", fetch_count, m_fc);
    bus_idle();
    tick();
    check("wr_pulse", wr_valid, 1'b0);
    check("wr_hold", {wr_adr, wr_dat}, {m_wadr, m_wdat});
  endtask

  task automatic drain();
    while (mq.size() > 0) do_read({$urandom} & 32'hFFFF_FFFC, 1'b0, '0);
  endtask

  // Drives one read on the waited instance and records ack|err after edges T..T+4
  task automatic ws_read(input logic [31:0] adr, input bit abort, output logic [4:0] mask);
    mask = '0;
    bus_w.core_adr = adr;
    bus_w.core_we  = 1'b0;
    bus_w.core_sel = 16'hFFFF;
    bus_w.core_cyc = 1'b1;
    bus_w.core_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      mask[i] = bus_w.core_ack | bus_w.core_err;
      if (mask[i] || (abort && i == 0)) begin
        bus_w.core_cyc = 1'b0;
        bus_w.core_stb = 1'b0;
      end
    end
    bus_w.core_cyc = 1'b0;
    bus_w.core_stb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0]  a, b, c, w;
    logic [127:0] wd;
    logic [4:0]   mask;
    int           op;

    bus_idle();
    bus0.core_adr  = '0;
    bus0.core_sel  = '0;
    bus0.core_wdat = '0;
    bus_w.core_adr  = '0;
    bus_w.core_sel  = '0;
    bus_w.core_wdat = '0;
    bus_w.core_we   = 1'b0;
    bus_w.core_cyc  = 1'b0;
    bus_w.core_stb  = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_outs", {bus0.core_ack, bus0.core_err, wr_valid, q_level, fetch_count}, '0);
    check("rst_rdat", bus0.core_rdat, '0);
    check("rst_wr", {wr_adr, wr_dat}, '0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", inst_ready, 1'b1);

    // Three pushes, three reads at lane 0
    a = $urandom; b = $urandom; c = $urandom;
    push(a); push(b); push(c);
    for (int i = 0; i < 3; i++) do_read(32'h0, 1'b0, '0);
    check("t1_fcount", fetch_count, 16'd3);
    check("t1_level", q_level, 4'd0);

    // Wait-state latency and abort on the second instance
    w = $urandom;
    inst_valid_w = 1'b1;
    inst_data_w  = w;
    tick();
    inst_valid_w = 1'b0;
    check("ws_level0", q_level_w, 4'd1);
    ws_read(32'h8, 1'b1, mask);
    check("ws_abort", mask, 5'b00000);
    check("ws_abort_level", q_level_w, 4'd1);
    ws_read(32'h8, 1'b0, mask);
    check("ws_latency", mask, 5'b00100);
    check("ws_level1", q_level_w, 4'd0);
    check("ws_rdat", bus_w.core_rdat, lane_word(32'h8, w));
    check("ws_fcount", fetch_count_w, 16'd1);

    // Randomized mix of pushes, reads and writes
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      if (op <= 1) push($urandom);
      else if (op == 2) do_read($urandom, $urandom_range(0, 1) == 1, $urandom);
      else do_write($urandom, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
    end

    // Overfill, then read with a simultaneous push while full
    drain();
    for (int i = 0; i < DEPTH + 1; i++) push($urandom);
    check("full_level", q_level, 4'(DEPTH));
    check("full_ready", inst_ready, 1'b0);
    do_read(32'h4, 1'b1, $urandom);
    check("full_push_rej", q_level, 4'(DEPTH - 1));
    drain();

    // Empty queue: push and pop in the same cycle
    w = $urandom;
    do_read(32'hC, 1'b1, w);
    check("emp_push_kept", q_level, 4'd1);
    do_read(32'hC, 1'b0, '0);

    // Write at 0x108 with lane 2 carrying 0x12345678; sel=0 write still acked
    wd = {$urandom, 32'h12345678, $urandom, $urandom};
    push($urandom);
    do_write(32'h108, wd, 16'hFFFF);
    check("t4_wr_dat", wr_dat, 32'h12345678);
    check("t4_wr_adr", wr_adr, 32'h108);
    do_write($urandom, {$urandom, $urandom, $urandom, $urandom}, 16'h0000);
    drain();

    // Empty-queue read at 0x4
    do_read(32'h4, 1'b0, '0);
    if (!ERR_EN) check("t5_filler", bus0.core_rdat, {4{FILLER}});

    // Reset asserted while ack is high
    push($urandom); push($urandom);
    bus0.core_adr = 32'h0;
    bus0.core_we  = 1'b0;
    bus0.core_cyc = 1'b1;
    bus0.core_stb = 1'b1;
    tick();
    check("t6_ack_pre", bus0.core_ack, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_ack_async", bus0.core_ack, 1'b0);
    check("t6_level", q_level, 4'd0);
    check("t6_fcount", fetch_count, 16'd0);
    bus_idle();
    mq.delete();
    m_fc   = 0;
    m_rdat = '0;
    tick();
    rst_n = 1'b1;
    tick();
    push($urandom);
    do_read(32'hC, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
